mdu: RTL and testbench

- Multiply/divide unit in the execute stage. Consumes the two register-file read operands (rs, rt) and owns the architectural HI/LO registers.
- Implements MIPS mult/multu/div/divu with fixed multi-cycle latency, plus mthi/mtlo writes.
- Drives hi/lo back toward the write-back mux for mfhi/mflo.
- Exposes busy so the hazard unit can stall any MDU instruction issued while an operation is in flight.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_if.sv | 14 +
 rtl/mdu_calc.sv | 54 +++++
 rtl/mdu.sv | 99 +++++++++
 tb/tb_mdu.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies and small op-class helpers used by the controller and decoder.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the MDU.
// master = pipeline side (issues ops, reads HI/LO), slave = MDU.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// Purely combinational arithmetic for the MDU. Produces the full HI/LO
// result for the presented op so the top only has to latch and time it.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_zero_o
);
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Signed divide works on magnitudes and re-applies signs afterwards:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        res_hi_o   = '0;
        res_lo_o   = '0;
        div_zero_o = (b_i == 32'd0);
        abs_a      = a_i[31] ? (~a_i + 32'd1) : a_i;
        abs_b      = b_i[31] ? (~b_i + 32'd1) : b_i;
        uq         = '0;
        ur         = '0;
        case (op_i)
            MDU_MULT: begin
                {res_hi_o, res_lo_o} = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
            end
            MDU_MULTU: begin
                {res_hi_o, res_lo_o} = {32'd0, a_i} * {32'd0, b_i};
            end
            MDU_DIV: begin
                if (!div_zero_o) begin
                    uq       = abs_a / abs_b;
                    ur       = abs_a % abs_b;
                    res_lo_o = (a_i[31] ^ b_i[31]) ? (~uq + 32'd1) : uq;
                    res_hi_o = a_i[31] ? (~ur + 32'd1) : ur;
                end
            end
            MDU_DIVU: begin
                if (!div_zero_o) begin
                    res_lo_o = a_i / b_i;
                    res_hi_o = a_i % b_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, models fixed mult/div latency with a
// down-counter and commits the pending result when the counter expires.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_dz;

    mdu_calc u_calc (
        .op_i       (bus.op),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .res_hi_o   (calc_hi),
        .res_lo_o   (calc_lo),
        .div_zero_o (calc_dz)
    );

    // Next-state: count down an in-flight op (commit on 1->0), otherwise
    // accept a new request. Requests while busy are simply dropped.
    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (busy_q) begin
            cnt_d = cnt_q - CNT_ONE;
            if ((cnt_q == CNT_ONE) && !pend_dz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (bus.start) begin
            if (op_is_mul(bus.op)) begin
                pend_hi_d = calc_hi;
                pend_lo_d = calc_lo;
                pend_dz_d = 1'b0;
                cnt_d     = CNT_MULT;
            end else if (op_is_div(bus.op)) begin
                pend_hi_d = calc_hi;
                pend_lo_d = calc_lo;
                pend_dz_d = calc_dz;
                cnt_d     = CNT_DIV;
            end else if (bus.op == MDU_MTHI) begin
                hi_d = bus.a;
            end else if (bus.op == MDU_MTLO) begin
                lo_d = bus.a;
            end
        end
    end

    // State registers; synchronous reset aborts any op without committing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= (cnt_d != '0);
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for the MDU: expected HI/LO pairs are queued when an op
// is issued and popped when the op completes.
module tb_mdu;
    import mdu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus_if ();

    exp_t exp_q[$];
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (bus_if.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_cycles));
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_hilo"}, {bus_if.hi, bus_if.lo}, e);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = MDU_NONE;
        bus_if.a     = '0;
        bus_if.b     = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", 64'(bus_if.busy), 64'd0);
        chk("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);

        // signed multiply -2 * 3
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_busy", 64'(bus_if.busy), 64'd1);
        chk("mult_hold", {bus_if.hi, bus_if.lo}, 64'd0);
        wait_idle("mult_lat", 5);
        sb_check("mult");

        // unsigned multiply max*max
        exp_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_hold", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_idle("multu_lat", 5);
        sb_check("multu");

        // signed divide -7 / 2 -> q=-3 r=-1
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div_lat", 10);
        sb_check("div");

        // divide by zero keeps HI/LO
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
        issue(MDU_DIVU, 32'h0000_0007, 32'h0000_0000);
        chk("divz_busy", 64'(bus_if.busy), 64'd1);
        wait_idle("divz_lat", 10);
        sb_check("divz");

        // signed overflow case
        exp_q.push_back('{hi: 32'h0000_0000, lo: 32'h8000_0000});
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf_lat", 10);
        sb_check("divovf");

        // MTHI / MTLO while idle
        issue(MDU_MTHI, 32'h1234_5678, 32'h0);
        chk("mthi_busy", 64'(bus_if.busy), 64'd0);
        chk("mthi_hilo", {bus_if.hi, bus_if.lo}, 64'h1234_5678_8000_0000);
        issue(MDU_MTLO, 32'hCAFE_F00D, 32'h0);
        chk("mtlo_hilo", {bus_if.hi, bus_if.lo}, 64'h1234_5678_CAFE_F00D);

        // NONE and code 7 are ignored
        issue(3'd7, 32'h5555_5555, 32'h1);
        chk("op7_busy", 64'(bus_if.busy), 64'd0);
        chk("op7_hilo", {bus_if.hi, bus_if.lo}, 64'h1234_5678_CAFE_F00D);
        issue(MDU_NONE, 32'h5555_5555, 32'h1);
        chk("none_hilo", {bus_if.hi, bus_if.lo}, 64'h1234_5678_CAFE_F00D);

        // requests during a MULT are dropped
        exp_q.push_back('{hi: 32'h0000_0000, lo: 32'h0000_002A});
        issue(MDU_MULT, 32'd6, 32'd7);
        tick();
        bus_if.op    = MDU_MTLO;
        bus_if.a     = 32'hDEAD_BEEF;
        bus_if.start = 1'b1;
        tick();
        bus_if.op    = MDU_DIV;
        bus_if.a     = 32'd100;
        bus_if.b     = 32'd7;
        tick();
        bus_if.start = 1'b0;
        chk("coll_hold", {bus_if.hi, bus_if.lo}, 64'h1234_5678_CAFE_F00D);
        wait_idle("coll_lat", 2);
        sb_check("coll");

        // start on the falling-busy edge is ignored, next edge accepted
        exp_q.push_back('{hi: 32'd2, lo: 32'd14});
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (9) tick();
        chk("b2b_busy_last", 64'(bus_if.busy), 64'd1);
        bus_if.op    = MDU_MULT;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd5;
        bus_if.start = 1'b1;
        tick();
        chk("b2b_edge_ignored", 64'(bus_if.busy), 64'd0);
        sb_check("b2b_div");
        exp_q.push_back('{hi: 32'd1, lo: 32'd4});
        bus_if.op = MDU_DIVU;
        bus_if.a  = 32'd9;
        bus_if.b  = 32'd2;
        tick();
        bus_if.start = 1'b0;
        chk("b2b_next_accept", 64'(bus_if.busy), 64'd1);
        wait_idle("b2b_lat", 10);
        sb_check("b2b_divu");

        // reset aborts an in-flight divide
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(bus_if.busy), 64'd0);
        chk("abort_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        repeat (15) tick();
        chk("abort_late_busy", 64'(bus_if.busy), 64'd0);
        chk("abort_late_hilo", {bus_if.hi, bus_if.lo}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
